// File: rtl/mips_instr_encoder_if.sv
// Request and instruction-stream bundle for the MIPS instruction encoder.
// Master drives requests and consumes bytes; slave is the encoder.
interface mips_instr_encoder_if #(
  parameter int COUNT_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_op;
  logic [4:0]         req_fields;
  logic               req_rd;
  logic [7:0]         req_imm;
  logic               flush;
  logic               instr_valid;
  logic               instr_ready;
  logic [7:0]         instr;
  logic               instr_last;
  logic               li_busy;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output req_valid, req_op, req_fields,
    output req_rd, req_imm, flush,
    output instr_ready,
    input  req_ready, instr_valid, instr,
    input  instr_last, li_busy, instr_count
  );

  modport slave (
    input  req_valid, req_op, req_fields,
    input  req_rd, req_imm, flush,
    input  instr_ready,
    output req_ready, instr_valid, instr,
    output instr_last, li_busy, instr_count
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes op requests into 8-bit MIPS instruction bytes; li -> lui/lli pair.
// Ports: clk, rst_n (async low), bus (slave: req_*, flush, instr_*, li_busy, instr_count).
module mips_instr_encoder #(
  parameter int COUNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  mips_instr_encoder_if.slave bus
);

  typedef enum logic {
    IDLE,
    LI_LO
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         instr_q, instr_d;
  logic [7:0]         lo_q, lo_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic [COUNT_W-1:0] cnt_q;
  logic               hs;
  logic               slot_free;
  logic               rdy;
  logic               accept;

  assign hs        = vld_q & bus.instr_ready;
  assign slot_free = ~vld_q | bus.instr_ready;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    lo_d    = lo_q;
    vld_d   = vld_q;
    last_d  = last_q;
    rdy     = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy    = slot_free & ~bus.flush;
        accept = bus.req_valid & rdy;
        if (accept) begin
          vld_d = 1'b1;
          if (bus.req_op == 3'b000) begin
            instr_d = {3'b000, bus.req_rd,
                       bus.req_imm[7:4]};
            lo_d    = {3'b000, bus.req_rd,
                       bus.req_imm[3:0]};
            last_d  = 1'b0;
            state_d = LI_LO;
          end else begin
            instr_d = {bus.req_op, bus.req_fields};
            last_d  = 1'b1;
          end
        end else if (bus.flush || bus.instr_ready) begin
          vld_d = 1'b0;
        end
      end
      LI_LO: begin
        // Lower beat follows the upper handshake with no bubble;
        // flush is ignored so the pair stays atomic.
        if (hs) begin
          instr_d = lo_q;
          last_d  = 1'b1;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= 8'h00;
      lo_q    <= 8'h00;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      lo_q    <= lo_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      if (hs) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.req_ready   = rdy;
  assign bus.instr_valid = vld_q;
  assign bus.instr       = instr_q;
  assign bus.instr_last  = last_q;
  assign bus.li_busy     = (state_q == LI_LO);
  assign bus.instr_count = cnt_q;

endmodule
